// File: rtl/hub_port_pkg.sv
// rtl/hub_port_pkg.sv - shared encodings, command record and address helpers for hub_port
package hub_port_pkg;

  // Transfer size encodings as seen on bus_s and cmd_size
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_WORD = 2'b01;
  localparam logic [1:0] SIZE_LONG = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  // Transfer sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // One queued command: write flag, size, start address, beats minus one, fill data
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [15:0] addr;
    logic [3:0]  len;
    logic [31:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // The reserved size code behaves exactly like a long transfer
  function automatic logic [1:0] legal_size(input logic [1:0] size);
    return (size == SIZE_ILL) ? SIZE_LONG : size;
  endfunction

  // Byte distance between consecutive beats of a burst
  function automatic logic [15:0] addr_step(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 16'd1;
      SIZE_WORD: return 16'd2;
      default:   return 16'd4;
    endcase
  endfunction

  // Force the start address onto the natural boundary of the transfer size
  function automatic logic [15:0] align_addr(input logic [15:0] addr, input logic [1:0] size);
    case (size)
      SIZE_BYTE: return addr;
      SIZE_WORD: return {addr[15:1], 1'b0};
      default:   return {addr[15:2], 2'b00};
    endcase
  endfunction

endpackage

// File: rtl/hub_port_fifo.sv
// rtl/hub_port_fifo.sv - synchronous command FIFO with occupancy count
module hub_port_fifo #(
  parameter int WIDTH = 55,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full blocks a push even when the same cycle pops, so ready depends on count only
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset flushes all entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Entry storage needs no reset: the count gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/hub_port.sv
// rtl/hub_port.sv - hub-bus initiator turning queued command bursts into single hub transfers
module hub_port
  import hub_port_pkg::*;
#(
  parameter int SLOT       = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_cog,
  input  logic        inp_res,
  input  logic        ena_bus,
  input  logic [7:0]  bus_sel,
  input  logic [7:0]  bus_ack,
  input  logic [31:0] bus_q,
  output logic        bus_r,
  output logic        bus_e,
  output logic        bus_w,
  output logic [1:0]  bus_s,
  output logic [15:0] bus_a,
  output logic [31:0] bus_d,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [1:0]  cmd_size,
  input  logic [15:0] cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  cmd_t          push_cmd;
  cmd_t          head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;

  logic [1:0]    state;
  logic          wr_q;
  logic [1:0]    size_q;
  logic [15:0]   addr_q;
  logic [3:0]    rem_q;
  logic [31:0]   data_q;
  logic          selected;
  logic          unused_bits;

  assign push_cmd  = '{wr: cmd_wr, size: cmd_size, addr: cmd_addr, len: cmd_len, data: cmd_data};
  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && !fifo_full;
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;

  hub_port_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_cog),
    .rst       (inp_res),
    .push      (fifo_push),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Transfer sequencer: fetch a command, align it, then one hub transfer per beat
  always_ff @(posedge clk_cog or posedge inp_res) begin
    if (inp_res) begin
      state    <= ST_IDLE;
      wr_q     <= 1'b0;
      size_q   <= SIZE_BYTE;
      addr_q   <= '0;
      rem_q    <= '0;
      data_q   <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            wr_q   <= head.wr;
            size_q <= legal_size(head.size);
            addr_q <= head.addr;
            rem_q  <= head.len;
            data_q <= head.data;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          addr_q <= align_addr(addr_q, size_q);
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus_ack[SLOT]) begin
            rsp_data <= wr_q ? 32'd0 : bus_q;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rem_q == 4'd0) begin
            state <= ST_IDLE;
          end else begin
            addr_q <= addr_q + addr_step(size_q);
            rem_q  <= rem_q - 4'd1;
            state  <= ST_WAIT;
          end
        end
      endcase
    end
  end

  // Drive the shared slot lines only in our own slot; the hub ORs every slot together
  always_comb begin
    selected = (state == ST_WAIT) && bus_sel[SLOT];
    bus_r    = selected;
    bus_e    = 1'b0;
    bus_w    = wr_q & selected;
    bus_s    = size_q & {2{selected}};
    bus_a    = addr_q & {16{selected}};
    bus_d    = data_q & {32{selected}};
  end

  assign rsp_valid = (state == ST_DONE);
  assign rsp_last  = rsp_valid && (rem_q == 4'd0);
  assign busy      = (fifo_count != '0) || (state != ST_IDLE);

  // Phase and foreign-slot bits are carried for the hub but not needed here
  assign unused_bits = ^{ena_bus, bus_sel, bus_ack};

endmodule
